// File: rtl/counter_pkg.sv
// Shared defaults for the counter capture path: operand widths, queue depth and entry width.
package counter_pkg;
    localparam int BUS_WIDTH_DEF   = 8;
    localparam int WRAP_WIDTH_DEF  = 4;
    localparam int DEPTH_DEF       = 4;
    localparam int ENTRY_WIDTH_DEF = WRAP_WIDTH_DEF + BUS_WIDTH_DEF;
endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO: a push becomes visible on pop_data one cycle later, with no bypass.
// A push while full is refused unless a pop happens on the same edge; pop_data is zero when empty.
module capture_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];
    assign level    = count;
endmodule

// File: rtl/counter_capture.sv
// Snapshots {wrap epoch, counter value} into a small queue; an entry appears one cycle after capture.
// Consumer pops with ready_i; captures arriving while full are dropped and flagged on sticky overflow_o.
module counter_capture
    import counter_pkg::*;
#(
    parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
    parameter int WRAP_WIDTH = WRAP_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst_i,
    input  logic [BUS_WIDTH-1:0]            count_i,
    input  logic                            cout_i,
    input  logic                            capture_i,
    input  logic                            ready_i,
    input  logic                            clr_i,
    output logic [WRAP_WIDTH+BUS_WIDTH-1:0] data_o,
    output logic                            valid_o,
    output logic [$clog2(DEPTH):0]          level_o,
    output logic                            overflow_o
);
    localparam int EW = WRAP_WIDTH + BUS_WIDTH;

    logic [WRAP_WIDTH-1:0] wrap;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  drop;

    assign pop  = valid_o & ready_i;
    assign drop = capture_i & full & ~pop;

    // Epoch rolls over silently; the snapshot uses the pre-increment value.
    always_ff @(posedge clk) begin
        if (rst_i)       wrap <= '0;
        else if (cout_i) wrap <= wrap + 1'b1;
    end

    // Set wins over clear when a drop coincides with clr_i.
    always_ff @(posedge clk) begin
        if (rst_i)      overflow_o <= 1'b0;
        else if (drop)  overflow_o <= 1'b1;
        else if (clr_i) overflow_o <= 1'b0;
    end

    capture_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst_i),
        .push      (capture_i),
        .push_data ({wrap, count_i}),
        .pop       (pop),
        .pop_data  (data_o),
        .full      (full),
        .empty     (empty),
        .level     (level_o)
    );

    assign valid_o = ~empty;
endmodule
